// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD stopwatch/countdown timer.
package bcd_timer_pkg;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] cc;
  } bcd_time_t;

  localparam int unsigned CC_MAX = 99;
  localparam int unsigned SS_MAX = 59;
  localparam int unsigned MM_MAX = 59;

  localparam int unsigned CC_LSB = 0;
  localparam int unsigned SS_LSB = 8;
  localparam int unsigned MM_LSB = 16;
  localparam int unsigned HH_LSB = 24;

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD modulo-MOD up/down counter with carry/borrow chaining,
// synchronous load and clamping of out-of-range preset values.
module bcd_digit_pair #(
  parameter int unsigned MOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       down,
  input  logic       cin,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       cout
);

  localparam int unsigned MAXV    = MOD - 1;
  localparam logic [3:0]  MAX_HI  = 4'(MAXV / 10);
  localparam logic [3:0]  MAX_LO  = 4'(MAXV % 10);
  localparam logic [7:0]  MAX_BCD = {MAX_HI, MAX_LO};

  logic [7:0] val_q, val_d;
  logic [7:0] ld_bin;
  logic       ld_bad;
  logic       at_lim;
  logic       step;

  always_comb begin
    ld_bin = 8'(load_val[7:4]) * 8'd10 + 8'(load_val[3:0]);
    // Non-BCD digits count as out of range, so they clamp to the maximum too.
    ld_bad = (load_val[7:4] > 4'd9) || (load_val[3:0] > 4'd9) || (ld_bin > 8'(MAXV));
    at_lim = down ? (val_q == '0) : (val_q == MAX_BCD);
    step   = en & cin;
    val_d  = val_q;
    if (load) begin
      val_d = ld_bad ? MAX_BCD : load_val;
    end else if (step) begin
      if (at_lim) begin
        val_d = down ? MAX_BCD : '0;
      end else if (down) begin
        val_d = (val_q[3:0] == 4'd0) ? {val_q[7:4] - 4'd1, 4'd9}
                                     : {val_q[7:4], val_q[3:0] - 4'd1};
      end else begin
        val_d = (val_q[3:0] == 4'd9) ? {val_q[7:4] + 4'd1, 4'd0}
                                     : {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val  = val_q;
  assign cout = step & at_lim;

endmodule

// File: rtl/bcd_timer.sv
// BCD HH:MM:SS.CC up/down timer with pause button and countdown expiry.
// Lap capture is built only when BCD_TIMER_LAP_EN is defined.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIV      = 500000,
  parameter int unsigned HOUR_MAX = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_btn,
  input  logic        down,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        lap_btn,
  output logic [31:0] count,
  output logic [31:0] lap,
  output logic        running,
  output logic        expired
);

  localparam int unsigned     PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    pause_sync_q, pause_sync_d;
  logic          pause_prev_q, pause_prev_d;
  logic [2:0]    live_q, live_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;

  bcd_time_t cnt;
  logic      tick, zero, count_en, expire_hit, pause_edge;
  logic      c_cc, c_ss, c_mm, hh_cout_unused;

  always_comb begin
    pause_sync_d = {pause_sync_q[0], pause_btn};
    pause_prev_d = pause_sync_q[1];
    live_d       = {live_q[1:0], 1'b1};
    // Edges are suppressed until the pipeline holds only post-reset samples,
    // so a button held through reset release does not register.
    pause_edge   = pause_sync_q[1] & ~pause_prev_q & live_q[2];

    tick       = running_q && (presc_q == PRESC_LAST);
    zero       = (cnt == '0);
    count_en   = tick & ~load & ~(down & zero);
    expire_hit = tick & ~load & down & zero;

    presc_d = presc_q;
    if (load)           presc_d = '0;
    else if (running_q) presc_d = tick ? '0 : presc_q + 1'b1;

    running_d = running_q ^ pause_edge;
    if (pause_edge && !running_q && down && zero) running_d = 1'b0;
    if (expire_hit)                               running_d = 1'b0;

    expired_d = expired_q;
    if (load)            expired_d = 1'b0;
    else if (expire_hit) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      pause_sync_q <= '0;
      pause_prev_q <= 1'b0;
      live_q       <= '0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pause_sync_q <= pause_sync_d;
      pause_prev_q <= pause_prev_d;
      live_q       <= live_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
    end
  end

  bcd_digit_pair #(.MOD(CC_MAX + 1)) u_cc (
    .clk(clk), .rst_n(rst), .en(count_en), .down(down), .cin(1'b1), .load(load),
    .load_val(load_val[CC_LSB +: 8]), .val(cnt.cc), .cout(c_cc)
  );
  bcd_digit_pair #(.MOD(SS_MAX + 1)) u_ss (
    .clk(clk), .rst_n(rst), .en(count_en), .down(down), .cin(c_cc), .load(load),
    .load_val(load_val[SS_LSB +: 8]), .val(cnt.ss), .cout(c_ss)
  );
  bcd_digit_pair #(.MOD(MM_MAX + 1)) u_mm (
    .clk(clk), .rst_n(rst), .en(count_en), .down(down), .cin(c_ss), .load(load),
    .load_val(load_val[MM_LSB +: 8]), .val(cnt.mm), .cout(c_mm)
  );
  bcd_digit_pair #(.MOD(HOUR_MAX)) u_hh (
    .clk(clk), .rst_n(rst), .en(count_en), .down(down), .cin(c_mm), .load(load),
    .load_val(load_val[HH_LSB +: 8]), .val(cnt.hh), .cout(hh_cout_unused)
  );

`ifdef BCD_TIMER_LAP_EN
  logic [1:0]  lap_sync_q, lap_sync_d;
  logic        lap_prev_q, lap_prev_d, lap_edge;
  logic [31:0] lap_q, lap_d;

  always_comb begin
    lap_sync_d = {lap_sync_q[0], lap_btn};
    lap_prev_d = lap_sync_q[1];
    lap_edge   = lap_sync_q[1] & ~lap_prev_q & live_q[2];
    lap_d      = lap_edge ? cnt : lap_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_sync_q <= '0;
      lap_prev_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      lap_sync_q <= lap_sync_d;
      lap_prev_q <= lap_prev_d;
      lap_q      <= lap_d;
    end
  end

  assign lap = lap_q;
`else
  logic lap_btn_unused;
  assign lap_btn_unused = lap_btn;
  assign lap            = '0;
`endif

  assign count   = cnt;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer with DIV=4, HOUR_MAX=24.
module tb_bcd_timer;

  logic        clk, rst, pause_btn, down, load, lap_btn;
  logic [31:0] load_val, count, lap;
  logic        running, expired;

  bcd_timer #(.DIV(4), .HOUR_MAX(24)) dut (
    .clk(clk), .rst(rst), .pause_btn(pause_btn), .down(down), .load(load),
    .load_val(load_val), .lap_btn(lap_btn), .count(count), .lap(lap),
    .running(running), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  typedef struct { logic [31:0] lv; logic dn; logic [31:0] e_load; logic [31:0] e_tick; } vec_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int unsigned n_cmp, n_err;
  logic [31:0] exp_lap;

  task automatic push_exp(input string name, input logic [31:0] e);
    exp_t x;
    x.name = name;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      x = sb.pop_front();
      if (act !== x.exp) begin
        n_err++;
        $display("FAIL %s: got %h required %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    push_exp(name, e);
    pop_cmp(act);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle lands on the third edge after the press; release leaves the synchroniser idle.
  task automatic pulse_pause();
    pause_btn = 1'b1;
    step(3);
    pause_btn = 1'b0;
    step(3);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; pause_btn = 1'b0; down = 1'b0; load = 1'b0; load_val = '0; lap_btn = 1'b0;
`ifdef BCD_TIMER_LAP_EN
    exp_lap = 32'h0001_0203;
`else
    exp_lap = 32'h0;
`endif
    vecs[0]  = '{32'h1234_5678, 1'b0, 32'h1234_5678, 32'h1234_5679};
    vecs[1]  = '{32'h2575_60A0, 1'b0, 32'h2359_5999, 32'h0000_0000};
    vecs[2]  = '{32'h9999_9999, 1'b1, 32'h2359_5999, 32'h2359_5998};
    vecs[3]  = '{32'h00AB_0000, 1'b1, 32'h0059_0000, 32'h0058_5999};
    vecs[4]  = '{32'h2360_599A, 1'b0, 32'h2359_5999, 32'h0000_0000};
    vecs[5]  = '{32'h0F00_0000, 1'b1, 32'h2300_0000, 32'h2259_5999};
    vecs[6]  = '{32'h2400_0000, 1'b0, 32'h2300_0000, 32'h2300_0001};
    vecs[7]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0001};
    vecs[8]  = '{32'h0000_0100, 1'b1, 32'h0000_0100, 32'h0000_0099};
    vecs[9]  = '{32'h0001_0000, 1'b1, 32'h0001_0000, 32'h0000_5999};
    vecs[10] = '{32'h1000_0000, 1'b1, 32'h1000_0000, 32'h0959_5999};

    // Reset asserted with both buttons held.
    #3 rst = 1'b0; pause_btn = 1'b1; lap_btn = 1'b1;
    #1;
    chk("rst_count", count, 32'h0);
    chk("rst_lap", lap, 32'h0);
    chk("rst_running", {31'b0, running}, 32'h0);
    chk("rst_expired", {31'b0, expired}, 32'h0);
    step(3);
    rst = 1'b1;
    step(6);
    chk("held_btn_no_run", {31'b0, running}, 32'h0);
    pause_btn = 1'b0; lap_btn = 1'b0;
    step(4);
    pulse_pause();
    chk("run_start", {31'b0, running}, 32'h1);

    for (int i = 0; i < 11; i++) begin
      load = 1'b1; load_val = vecs[i].lv; down = vecs[i].dn;
      push_exp($sformatf("vec%0d_load", i), vecs[i].e_load);
      push_exp($sformatf("vec%0d_tick", i), vecs[i].e_tick);
      push_exp($sformatf("vec%0d_expired", i), 32'h0);
      step(1);
      load = 1'b0;
      pop_cmp(count);
      step(4);
      pop_cmp(count);
      pop_cmp({31'b0, expired});
    end

    // Countdown to expiry.
    load = 1'b1; load_val = 32'h2; down = 1'b1;
    step(1); load = 1'b0;
    step(8);
    chk("cd_zero_count", count, 32'h0);
    chk("cd_zero_expired", {31'b0, expired}, 32'h0);
    chk("cd_zero_running", {31'b0, running}, 32'h1);
    step(4);
    chk("cd_exp_count", count, 32'h0);
    chk("cd_exp_expired", {31'b0, expired}, 32'h1);
    chk("cd_exp_running", {31'b0, running}, 32'h0);
    pulse_pause();
    chk("cd_blocked_running", {31'b0, running}, 32'h0);
    chk("cd_blocked_expired", {31'b0, expired}, 32'h1);
    load = 1'b1; load_val = 32'h5;
    step(1); load = 1'b0;
    chk("reload_count", count, 32'h5);
    chk("reload_expired", {31'b0, expired}, 32'h0);
    chk("reload_running", {31'b0, running}, 32'h0);
    down = 1'b0;
    pulse_pause();
    chk("resume_running", {31'b0, running}, 32'h1);

    // Pause edge coinciding with a tick.
    load = 1'b1; load_val = 32'h9;
    step(1); load = 1'b0;
    step(1); pause_btn = 1'b1;
    step(3);
    chk("coinc_count", count, 32'h10);
    chk("coinc_running", {31'b0, running}, 32'h0);
    pause_btn = 1'b0;
    step(20);
    chk("coinc_hold", count, 32'h10);
    pause_btn = 1'b1;
    step(3);
    chk("coinc_resume", {31'b0, running}, 32'h1);
    pause_btn = 1'b0;
    step(4);

    // Pause with prescaler at its last value; resume ticks on the next edge.
    load = 1'b1; load_val = 32'h20;
    step(1); load = 1'b0; pause_btn = 1'b1;
    step(3);
    chk("presc_pause_running", {31'b0, running}, 32'h0);
    chk("presc_pause_count", count, 32'h20);
    pause_btn = 1'b0;
    step(20);
    chk("presc_hold", count, 32'h20);
    pause_btn = 1'b1;
    step(3);
    chk("presc_resume_running", {31'b0, running}, 32'h1);
    chk("presc_resume_count", count, 32'h20);
    step(1);
    chk("presc_resume_tick", count, 32'h21);
    pause_btn = 1'b0;

    // Direction change mid-run.
    load = 1'b1; load_val = 32'h50; down = 1'b0;
    step(1); load = 1'b0;
    step(4);
    chk("dir_up", count, 32'h51);
    down = 1'b1;
    step(4);
    chk("dir_down", count, 32'h50);
    down = 1'b0;

    // Lap capture.
    load = 1'b1; load_val = 32'h0001_0203;
    step(1); load = 1'b0; lap_btn = 1'b1;
    step(3);
    chk("lap_value", lap, exp_lap);
    step(1);
    chk("lap_count_runs", count, 32'h0001_0204);
    lap_btn = 1'b0;

    // Asynchronous reset mid-run.
    step(2);
    load = 1'b1; load_val = 32'h0000_1234;
    step(1); load = 1'b0;
    chk("pre_rst_count", count, 32'h0000_1234);
    step(1);
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 32'h0);
    chk("async_rst_lap", lap, 32'h0);
    chk("async_rst_running", {31'b0, running}, 32'h0);
    chk("async_rst_expired", {31'b0, expired}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(2);
    pulse_pause();
    pulse_pause();
    pulse_pause();
    chk("three_edges_running", {31'b0, running}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 SHALL have parameter DIV, default 500000, clk cycles per centisecond tick (>=2).
REQ-002 SHALL have parameter HOUR_MAX, default 100, hour wrap modulus (2..100).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pause_btn  input  1  raw async button; each rising edge toggles the run state.
REQ-006 SHALL have port down  input  1  1 = count down, 0 = count up; sampled at each tick.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  32  BCD preset {HH,MM,SS,CC}.
REQ-009 SHALL have port lap_btn  input  1  raw async button; rising edge captures lap.
REQ-010 SHALL have port count  output  32  BCD time {hh_hi,hh_lo,mm_hi,mm_lo,ss_hi,ss_lo,cc_hi,cc_lo}.
REQ-011 SHALL have port lap  output  32  last captured count.
REQ-012 SHALL have port running  output  1  run state.
REQ-013 SHALL have port expired  output  1  sticky countdown-complete flag.

Function
REQ-014 SHALL synchronise pause_btn and lap_btn through two flops, then detect rising edges; edge-to-effect latency is 3 clk.
REQ-015 SHALL hold a prescaler that advances only while running, emits tick at DIV-1, then returns to 0; it holds its value while paused.
REQ-016 SHALL, on tick in up mode, increment: CC 00..99, SS 00..59, MM 00..59, HH 00..HOUR_MAX-1, each field carrying into the next; HOUR_MAX-1:59:59.99 wraps to 00:00:00.00.
REQ-017 SHALL, on tick in down mode, decrement with borrow, using the same limits.
REQ-018 SHALL, on tick in down mode with count 00:00:00.00, keep count at zero, set expired, and clear running in the same edge.
REQ-019 SHALL ignore a pause edge that would set running while down=1 and count is zero; expired stays set.
REQ-020 SHALL give load priority over tick: count <= load_val, prescaler <= 0, expired <= 0, running unchanged.
REQ-021 SHALL clamp each out-of-range loaded field to its maximum legal value, per digit pair (e.g. SS=75 -> 59, HH>=HOUR_MAX -> HOUR_MAX-1).
REQ-022 SHALL apply a tick using the old run state when a tick and a pause edge coincide; the toggle takes effect the next cycle.
REQ-023 SHALL apply a change of down mid-run at the next tick, with no glitch on count.
REQ-024 SHALL make count change only on a tick or load edge; all outputs are registered.

Reset
REQ-025 SHALL, while rst=0, force count=0, lap=0, running=0, expired=0, prescaler=0, and edge-detect flops to 0, irrespective of clk.
REQ-026 SHALL produce no spurious pause or lap edge on release from reset while a button is held.

Configuration
REQ-027 SHALL provide lap capture only when macro BCD_TIMER_LAP_EN is defined; with it, a lap edge loads lap <= count, including while paused.
REQ-028 SHALL, without BCD_TIMER_LAP_EN, keep lap_btn present but ignored, hold lap constant 0, and omit the lap register and synchroniser.

Structure
REQ-029 SHALL place the following in package bcd_timer_pkg: the BCD time struct typedef (4 fields x 2 digits), the constants CC_MAX=99, SS_MAX=59, MM_MAX=59, and the field bit offsets.
REQ-030 SHALL instantiate four copies of sub-module bcd_digit_pair: a two-digit BCD modulo-N up/down counter with enable, carry/borrow in/out, load, and clamp (N=100, 60, 60, HOUR_MAX).
REQ-031 SHALL contain the prescaler, synchronisers, run/expired control, and lap register at the top level.

Verification (DIV=4, HOUR_MAX=24)
REQ-032 SHALL verify: rst low mid-run with count=00:00:12.34 -> all outputs 0 asynchronously; after release, 3 pause edges -> running=1.
REQ-033 SHALL verify: load 23:59:59.99 while up and running, then 1 tick -> count 00:00:00.00 with no expired.
REQ-034 SHALL verify: load 00:00:00.02 with down=1 and running -> after 2 ticks count 0, then at the 3rd tick expired=1, running=0; a further pause edge leaves running=0.
REQ-035 SHALL verify: load_val 0x25_75_60_A0 -> count 23:59:59.99.
REQ-036 SHALL verify: pause edge coinciding with a tick at 00:00:00.09 -> count 00:00:00.10, then held for 20 cycles; resume continues from the stored prescaler value.
REQ-037 SHALL verify: with BCD_TIMER_LAP_EN, lap edge at count 00:01:02.03 -> lap=0x00010203 while count keeps running; without the macro, lap stays 0.
